// File: rtl/bounce_gen.sv
// Mechanical switch emulator: replays a level change as a burst of bounce edges, then a settle hold.
// Optional BOUNCE_GEN_LFSR_EN replaces the fixed edge spacing with LFSR-random gaps.
module bounce_gen #(
  parameter int          N_BOUNCE   = 2,
  parameter int          GW         = 4,
  parameter int          FIX_GAP    = 4,
  parameter int          SETTLE_CYC = 8,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic target,
  output logic sw,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

  localparam logic [4:0]  LAST_TOGGLE = 5'(2 * N_BOUNCE);
  localparam logic [8:0]  SETTLE_LOAD = 9'(SETTLE_CYC);
  localparam logic [15:0] SEED_EFF    = (SEED == 16'h0) ? 16'hACE1 : SEED;

  if (N_BOUNCE < 0 || N_BOUNCE > 15) begin : g_bad_n_bounce
    $error("bounce_gen: N_BOUNCE out of range 0..15");
  end
  if (GW < 1 || GW > 8) begin : g_bad_gw
    $error("bounce_gen: GW out of range 1..8");
  end
  if (FIX_GAP < 1 || FIX_GAP > 255) begin : g_bad_fix_gap
    $error("bounce_gen: FIX_GAP out of range 1..255");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
    $error("bounce_gen: SETTLE_CYC out of range 1..255");
  end
  if (SEED_EFF == 16'h0) begin : g_bad_seed
    $error("bounce_gen: LFSR seed must be nonzero");
  end

  state_t      state;
  logic        level;
  logic        tgt_reg;
  logic [4:0]  edge_cnt;
  logic [8:0]  gap_cnt;
  logic [8:0]  gap;

`ifdef BOUNCE_GEN_LFSR_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic        gap_load;

  // Gap is taken from the current LFSR value; the LFSR steps only when that gap is consumed.
  assign gap       = 9'(lfsr[GW-1:0]) + 9'd1;
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
  assign gap_load  = ((state == IDLE) && (target != level) && (N_BOUNCE != 0)) ||
                     ((state == BOUNCE) && (gap_cnt == 9'd1) && (edge_cnt != LAST_TOGGLE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= SEED_EFF;
    end else if (gap_load) begin
      lfsr <= lfsr_next;
    end
  end
`else
  assign gap = 9'(FIX_GAP);
`endif

  // gap_cnt doubles as the settle timer, so each phase ends when the counter reaches one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sw       <= 1'b0;
      level    <= 1'b0;
      tgt_reg  <= 1'b0;
      edge_cnt <= 5'd0;
      gap_cnt  <= 9'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sw <= level;
          if (target != level) begin
            tgt_reg  <= target;
            sw       <= target;
            edge_cnt <= 5'd1;
            busy     <= 1'b1;
            if (N_BOUNCE == 0) begin
              state   <= SETTLE;
              gap_cnt <= SETTLE_LOAD;
            end else begin
              state   <= BOUNCE;
              gap_cnt <= gap;
            end
          end
        end
        BOUNCE: begin
          if (gap_cnt == 9'd1) begin
            sw       <= ~sw;
            edge_cnt <= edge_cnt + 5'd1;
            if (edge_cnt == LAST_TOGGLE) begin
              state   <= SETTLE;
              gap_cnt <= SETTLE_LOAD;
            end else begin
              gap_cnt <= gap;
            end
          end else begin
            gap_cnt <= gap_cnt - 9'd1;
          end
        end
        SETTLE: begin
          if (gap_cnt == 9'd1) begin
            state    <= IDLE;
            level    <= tgt_reg;
            sw       <= tgt_reg;
            busy     <= 1'b0;
            done     <= 1'b1;
            edge_cnt <= 5'd0;
            gap_cnt  <= 9'd0;
          end else begin
            gap_cnt <= gap_cnt - 9'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 SHALL have parameter N_BOUNCE, default 2, bounce pairs before settling (range 0..15).
REQ-002 SHALL have parameter GW, default 4, width of the random gap field (range 1..8).
REQ-003 SHALL have parameter FIX_GAP, default 4, edge spacing in cycles when LFSR disabled (range 1..255).
REQ-004 SHALL have parameter SETTLE_CYC, default 8, stable hold after final edge (range 1..255).
REQ-005 SHALL have parameter SEED, default 16'hACE1, LFSR initial value.
REQ-006 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port target  input  1  requested clean switch level.
REQ-009 SHALL have port sw  output  1  emulated mechanical switch, registered, bouncing on level change.
REQ-010 SHALL have port busy  output  1  high in BOUNCE and SETTLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a transition completes.

Function
REQ-012 SHALL implement FSM states IDLE, BOUNCE, SETTLE, plus internal registers level, tgt_reg, edge_cnt (5 b), gap_cnt (9 b), lfsr (16 b).
REQ-013 SHALL, in IDLE at edge t with target != level, capture tgt_reg = target, set sw = target at t+1, edge_cnt = 1, load gap_cnt with next gap, go to BOUNCE.
REQ-014 SHALL, in IDLE with target == level, hold all state, sw = level.
REQ-015 SHALL, in BOUNCE, toggle sw exactly gap cycles after the previous edge, increment edge_cnt, reload gap.
REQ-016 SHALL produce exactly 2*N_BOUNCE+1 edges total; final sw equals tgt_reg.
REQ-017 SHALL, on the final edge, enter SETTLE and hold sw for SETTLE_CYC cycles with no toggles.
REQ-018 SHALL, at SETTLE expiry, return to IDLE, set level = tgt_reg, assert done for exactly that one cycle.
REQ-019 SHALL, with N_BOUNCE = 0, produce one clean edge followed by SETTLE.
REQ-020 SHALL ignore target changes in BOUNCE and SETTLE; a mismatch remaining at IDLE starts a new transition on the next cycle (done and new start may be adjacent cycles).
REQ-021 SHALL compute gap without overflow; gap_cnt width 9 b covers 1..256.
REQ-022 SHALL keep busy = 1 from the first edge cycle through the last SETTLE cycle; busy = 0 in the done cycle.

Reset
REQ-023 SHALL, on reset asserted, immediately force state IDLE, sw = 0, level = 0, tgt_reg = 0, busy = 0, done = 0, counters 0, lfsr = SEED (16'hACE1 if SEED = 0).
REQ-024 SHALL abort any in-progress BOUNCE/SETTLE on reset with no done pulse; after release, a high target starts a fresh transition.

Configuration
REQ-025 SHALL use macro BOUNCE_GEN_LFSR_EN.
REQ-026 SHALL, with BOUNCE_GEN_LFSR_EN defined, use gap = lfsr[GW-1:0] + 1; lfsr is Fibonacci x^16+x^15+x^13+x^4+1, advancing once per gap load.
REQ-027 SHALL, without BOUNCE_GEN_LFSR_EN, use gap = FIX_GAP for every edge; lfsr logic absent.

Verification
REQ-028 SHALL cover: LFSR off, N_BOUNCE=2, FIX_GAP=4, SETTLE_CYC=8, target 0->1 seen at t -> sw edges at t+1, t+5, t+9, t+13, t+17; sw=1 from t+17; done=1 at t+25 only.
REQ-029 SHALL cover: same config, then target 1->0 -> mirror sequence ending sw=0, level=0, single done pulse.
REQ-030 SHALL cover: N_BOUNCE=0, target 0->1 -> single edge at t+1, done at t+9, busy high t+1..t+8.
REQ-031 SHALL cover: target toggles 1->0 at t+6 during BOUNCE -> sequence unaffected, done at t+25, new 1->0 transition starts at t+26 edge.
REQ-032 SHALL cover: reset asserted at t+7 mid-BOUNCE -> sw=0, busy=0 same cycle, no done; target held 1 after release -> new transition from first post-release edge.
REQ-033 SHALL cover: LFSR on, SEED=16'hACE1, GW=4 -> every edge spacing in 1..16, 2*N_BOUNCE+1 edges, sequence identical across two runs.
